// File: rtl/cv32e40s_pkg.sv
// Shared types for the PMP check scheduler: privilege levels, PMP access types,
// scheduler FSM states and the captured request used for the second half of a split.
package cv32e40s_pkg;

  typedef enum logic [1:0] {
    PRIV_LVL_U = 2'b00,
    PRIV_LVL_S = 2'b01,
    PRIV_LVL_M = 2'b11
  } privlvl_t;

  typedef enum logic [1:0] {
    PMP_ACC_EXEC  = 2'b00,
    PMP_ACC_WRITE = 2'b01,
    PMP_ACC_READ  = 2'b10
  } pmp_req_e;

  typedef enum logic [0:0] {
    PMP_SCHED_IDLE  = 1'b0,
    PMP_SCHED_SPLIT = 1'b1
  } pmp_sched_state_e;

  typedef struct packed {
    logic [33:0] addr;
    pmp_req_e    req_type;
    logic        dbg;
    privlvl_t    priv;
  } pmp_sched_req_t;

  // First byte of the word following addr; wraps at the top of the 34-bit space.
  function automatic logic [33:0] pmp_next_word(input logic [33:0] addr);
    return {addr[33:2] + 32'd1, 2'b00};
  endfunction

endpackage

// File: rtl/cv32e40s_pmp_rr_arb.sv
// Two-way round-robin arbiter: bit 0 = IF, bit 1 = LSU. A tie goes to the side
// that did not win last; the history only moves when a grant is actually taken.
module cv32e40s_pmp_rr_arb (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_valid,
  input  logic       i_fire,
  output logic [1:0] o_gnt
);

  logic r_last_lsu;

  always_comb begin
    o_gnt = 2'b00;
    case (i_valid)
      2'b01:   o_gnt = 2'b01;
      2'b10:   o_gnt = 2'b10;
      2'b11:   o_gnt = r_last_lsu ? 2'b01 : 2'b10;
      default: o_gnt = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_lsu <= 1'b0;
    end else if (i_fire) begin
      r_last_lsu <= o_gnt[1];
    end
  end

endmodule

// File: rtl/cv32e40s_pmp_check_sched.sv
// Shares one PMP checker between IF and LSU; LSU accesses crossing a word are checked
// in two halves. Optional sticky fault capture: CV32E40S_PMP_SCHED_ERR_CAPTURE_EN.
//   state           | meaning
//   PMP_SCHED_IDLE  | arbitrate, check granted request, unsplit response next cycle
//   PMP_SCHED_SPLIT | check second word of a split LSU access, both requesters stalled
module cv32e40s_pmp_check_sched
  import cv32e40s_pkg::*;
#(
  parameter int PMP_GRANULARITY = 0,
  parameter int PMP_NUM_REGIONS = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  privlvl_t    priv_lvl_i,
  input  logic        if_req_valid_i,
  output logic        if_req_ready_o,
  input  logic [33:0] if_req_addr_i,
  input  logic        if_req_dbg_i,
  output logic        if_rsp_valid_o,
  output logic        if_rsp_err_o,
  input  logic        lsu_req_valid_i,
  output logic        lsu_req_ready_o,
  input  logic [33:0] lsu_req_addr_i,
  input  logic [1:0]  lsu_req_size_i,
  input  logic        lsu_req_we_i,
  input  logic        lsu_req_dbg_i,
  output logic        lsu_rsp_valid_o,
  output logic        lsu_rsp_err_o,
  output logic [33:0] pmp_req_addr_o,
  output pmp_req_e    pmp_req_type_o,
  output logic        pmp_req_dbg_o,
  output privlvl_t    pmp_priv_lvl_o,
  input  logic        pmp_req_err_i
`ifdef CV32E40S_PMP_SCHED_ERR_CAPTURE_EN
  ,
  output logic [33:0] err_addr_o,
  output pmp_req_e    err_type_o,
  output logic        err_valid_o,
  input  logic        err_clear_i
`endif
);

  // Granules are at least a word, so the second half always starts on the next word.
  if (PMP_GRANULARITY < 0 || PMP_NUM_REGIONS < 0) begin : g_bad_params
  end

  pmp_sched_state_e r_state;
  pmp_sched_req_t   r_req;
  logic             r_err0;
  logic             r_if_rsp_valid;
  logic             r_if_rsp_err;
  logic             r_lsu_rsp_valid;
  logic             r_lsu_rsp_err;

  logic [1:0]       w_gnt;
  logic             w_idle;
  logic             w_if_fire;
  logic             w_lsu_fire;
  logic [3:0]       w_lsu_span;
  logic             w_split;
  pmp_req_e         w_lsu_type;

  assign w_idle = (r_state == PMP_SCHED_IDLE);

  cv32e40s_pmp_rr_arb u_arb (
    .clk     (clk),
    .rst     (rst),
    .i_valid ({lsu_req_valid_i, if_req_valid_i}),
    .i_fire  (w_if_fire | w_lsu_fire),
    .o_gnt   (w_gnt)
  );

  assign if_req_ready_o  = w_idle & ~rst & w_gnt[0];
  assign lsu_req_ready_o = w_idle & ~rst & w_gnt[1];
  assign w_if_fire       = if_req_valid_i & if_req_ready_o;
  assign w_lsu_fire      = lsu_req_valid_i & lsu_req_ready_o;

  assign w_lsu_span = {2'b00, lsu_req_addr_i[1:0]} + (4'd1 << lsu_req_size_i);
  assign w_split    = (w_lsu_span > 4'd4);

  always_comb begin
    if (lsu_req_we_i) w_lsu_type = PMP_ACC_WRITE;
    else              w_lsu_type = PMP_ACC_READ;
  end

  always_comb begin
    pmp_req_addr_o = '0;
    pmp_req_type_o = PMP_ACC_READ;
    pmp_req_dbg_o  = 1'b0;
    pmp_priv_lvl_o = priv_lvl_i;
    if (!w_idle) begin
      pmp_req_addr_o = pmp_next_word(r_req.addr);
      pmp_req_type_o = r_req.req_type;
      pmp_req_dbg_o  = r_req.dbg;
      pmp_priv_lvl_o = r_req.priv;
    end else if (w_if_fire) begin
      pmp_req_addr_o = if_req_addr_i;
      pmp_req_type_o = PMP_ACC_EXEC;
      pmp_req_dbg_o  = if_req_dbg_i;
    end else if (w_lsu_fire) begin
      pmp_req_addr_o = lsu_req_addr_i;
      pmp_req_type_o = w_lsu_type;
      pmp_req_dbg_o  = lsu_req_dbg_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= PMP_SCHED_IDLE;
      r_req           <= '0;
      r_err0          <= 1'b0;
      r_if_rsp_valid  <= 1'b0;
      r_if_rsp_err    <= 1'b0;
      r_lsu_rsp_valid <= 1'b0;
      r_lsu_rsp_err   <= 1'b0;
    end else begin
      r_if_rsp_valid  <= w_if_fire;
      r_if_rsp_err    <= w_if_fire & pmp_req_err_i;
      r_lsu_rsp_valid <= 1'b0;
      r_lsu_rsp_err   <= 1'b0;
      case (r_state)
        PMP_SCHED_IDLE: begin
          if (w_lsu_fire) begin
            if (w_split) begin
              r_state        <= PMP_SCHED_SPLIT;
              r_err0         <= pmp_req_err_i;
              r_req.addr     <= lsu_req_addr_i;
              r_req.req_type <= w_lsu_type;
              r_req.dbg      <= lsu_req_dbg_i;
              r_req.priv     <= priv_lvl_i;
            end else begin
              r_lsu_rsp_valid <= 1'b1;
              r_lsu_rsp_err   <= pmp_req_err_i;
            end
          end
        end
        PMP_SCHED_SPLIT: begin
          r_lsu_rsp_valid <= 1'b1;
          r_lsu_rsp_err   <= r_err0 | pmp_req_err_i;
          r_state         <= PMP_SCHED_IDLE;
        end
        default: r_state <= PMP_SCHED_IDLE;
      endcase
    end
  end

  assign if_rsp_valid_o  = r_if_rsp_valid;
  assign if_rsp_err_o    = r_if_rsp_err;
  assign lsu_rsp_valid_o = r_lsu_rsp_valid;
  assign lsu_rsp_err_o   = r_lsu_rsp_err;

`ifdef CV32E40S_PMP_SCHED_ERR_CAPTURE_EN
  logic        r_err_valid;
  logic [33:0] r_err_addr;
  pmp_req_e    r_err_type;
  logic        w_check;

  assign w_check = w_if_fire | w_lsu_fire | ~w_idle;

  // Clear has priority so software never loses a clear to a racing fault.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_valid <= 1'b0;
      r_err_addr  <= '0;
      r_err_type  <= PMP_ACC_READ;
    end else if (err_clear_i) begin
      r_err_valid <= 1'b0;
    end else if (w_check && pmp_req_err_i && !r_err_valid) begin
      r_err_valid <= 1'b1;
      r_err_addr  <= pmp_req_addr_o;
      r_err_type  <= pmp_req_type_o;
    end
  end

  assign err_valid_o = r_err_valid;
  assign err_addr_o  = r_err_addr;
  assign err_type_o  = r_err_type;
`endif

endmodule

// File: tb/tb_cv32e40s_pmp_check_sched.sv
// Scoreboard bench for the PMP check scheduler: expected responses are queued at each
// handshake and compared (value and cycle) when the scheduler returns them.
module tb_cv32e40s_pmp_check_sched;
  import cv32e40s_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  privlvl_t    priv_lvl_i;
  logic        if_req_valid_i, if_req_ready_o, if_req_dbg_i, if_rsp_valid_o, if_rsp_err_o;
  logic [33:0] if_req_addr_i;
  logic        lsu_req_valid_i, lsu_req_ready_o, lsu_req_we_i, lsu_req_dbg_i;
  logic        lsu_rsp_valid_o, lsu_rsp_err_o;
  logic [33:0] lsu_req_addr_i;
  logic [1:0]  lsu_req_size_i;
  logic [33:0] pmp_req_addr_o;
  pmp_req_e    pmp_req_type_o;
  logic        pmp_req_dbg_o;
  privlvl_t    pmp_priv_lvl_o;
  logic        pmp_req_err_i;
`ifdef CV32E40S_PMP_SCHED_ERR_CAPTURE_EN
  logic [33:0] err_addr_o;
  pmp_req_e    err_type_o;
  logic        err_valid_o;
  logic        err_clear_i;
`endif

  logic [33:0] fault_a, fault_b;
  logic        fault_en;

  typedef struct {
    logic        err;
    int unsigned due;
  } exp_t;

  exp_t        if_q[$];
  exp_t        lsu_q[$];
  exp_t        mon_e;
  int unsigned cyc = 0;
  int          n_pass = 0;
  int          n_total = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in for the PMP checker: faults on up to two chosen addresses.
  assign pmp_req_err_i = fault_en && ((pmp_req_addr_o == fault_a) || (pmp_req_addr_o == fault_b));

  cv32e40s_pmp_check_sched #(.PMP_GRANULARITY(0), .PMP_NUM_REGIONS(0)) dut (
    .clk             (clk),
    .rst             (rst),
    .priv_lvl_i      (priv_lvl_i),
    .if_req_valid_i  (if_req_valid_i),
    .if_req_ready_o  (if_req_ready_o),
    .if_req_addr_i   (if_req_addr_i),
    .if_req_dbg_i    (if_req_dbg_i),
    .if_rsp_valid_o  (if_rsp_valid_o),
    .if_rsp_err_o    (if_rsp_err_o),
    .lsu_req_valid_i (lsu_req_valid_i),
    .lsu_req_ready_o (lsu_req_ready_o),
    .lsu_req_addr_i  (lsu_req_addr_i),
    .lsu_req_size_i  (lsu_req_size_i),
    .lsu_req_we_i    (lsu_req_we_i),
    .lsu_req_dbg_i   (lsu_req_dbg_i),
    .lsu_rsp_valid_o (lsu_rsp_valid_o),
    .lsu_rsp_err_o   (lsu_rsp_err_o),
    .pmp_req_addr_o  (pmp_req_addr_o),
    .pmp_req_type_o  (pmp_req_type_o),
    .pmp_req_dbg_o   (pmp_req_dbg_o),
    .pmp_priv_lvl_o  (pmp_priv_lvl_o),
    .pmp_req_err_i   (pmp_req_err_i)
`ifdef CV32E40S_PMP_SCHED_ERR_CAPTURE_EN
    ,
    .err_addr_o      (err_addr_o),
    .err_type_o      (err_type_o),
    .err_valid_o     (err_valid_o),
    .err_clear_i     (err_clear_i)
`endif
  );

  function automatic logic faulty(input logic [33:0] a);
    return fault_en && ((a == fault_a) || (a == fault_b));
  endfunction

  function automatic logic splits(input logic [33:0] a, input logic [1:0] sz);
    int span;
    span = int'(a[1:0]) + (1 << sz);
    return span > 4;
  endfunction

  function automatic logic [33:0] next_word(input logic [33:0] a);
    logic [33:0] r;
    r = (a & ~34'h3) + 34'h4;
    return r;
  endfunction

  // Response monitor: pops the scoreboard and checks value and arrival cycle.
  always @(negedge clk) begin
    if (if_rsp_valid_o === 1'b1 && lsu_rsp_valid_o === 1'b1) begin
      n_total++;
      $display("FAIL both_rsp_valid: if and lsu responses together at cycle %0d", cyc);
    end
    if (if_rsp_valid_o === 1'b1) begin
      n_total++;
      if (if_q.size() == 0) begin
        $display("FAIL if_rsp_unexpected: got response at cycle %0d, want none", cyc);
      end else begin
        mon_e = if_q.pop_front();
        if (if_rsp_err_o !== mon_e.err || cyc != mon_e.due)
          $display("FAIL if_rsp: got err=%0b cycle=%0d, want err=%0b cycle=%0d", if_rsp_err_o, cyc, mon_e.err, mon_e.due);
        else n_pass++;
      end
    end
    if (lsu_rsp_valid_o === 1'b1) begin
      n_total++;
      if (lsu_q.size() == 0) begin
        $display("FAIL lsu_rsp_unexpected: got response at cycle %0d, want none", cyc);
      end else begin
        mon_e = lsu_q.pop_front();
        if (lsu_rsp_err_o !== mon_e.err || cyc != mon_e.due)
          $display("FAIL lsu_rsp: got err=%0b cycle=%0d, want err=%0b cycle=%0d", lsu_rsp_err_o, cyc, mon_e.err, mon_e.due);
        else n_pass++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    if_req_valid_i  = 1'b0;
    lsu_req_valid_i = 1'b0;
    if_req_dbg_i    = 1'b0;
    lsu_req_dbg_i   = 1'b0;
    lsu_req_we_i    = 1'b0;
  endtask

  task automatic drive_lsu(input logic [33:0] a, input logic [1:0] sz, input logic we);
    lsu_req_valid_i = 1'b1;
    lsu_req_addr_i  = a;
    lsu_req_size_i  = sz;
    lsu_req_we_i    = we;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    if_req_valid_i = 1'b1; if_req_addr_i = 34'h40;
    drive_lsu(34'h80, 2'd2, 1'b0);
    priv_lvl_i = PRIV_LVL_U;
    #1;
    n_total++; if (if_req_ready_o !== 1'b0) $display("FAIL rst_if_ready: got %0b want 0", if_req_ready_o); else n_pass++;
    n_total++; if (lsu_req_ready_o !== 1'b0) $display("FAIL rst_lsu_ready: got %0b want 0", lsu_req_ready_o); else n_pass++;
    n_total++; if (pmp_req_addr_o !== 34'h0) $display("FAIL rst_pmp_addr: got %0h want 0", pmp_req_addr_o); else n_pass++;
    n_total++; if (pmp_req_type_o !== PMP_ACC_READ) $display("FAIL rst_pmp_type: got %0d want %0d", pmp_req_type_o, PMP_ACC_READ); else n_pass++;
    n_total++; if (pmp_priv_lvl_o !== PRIV_LVL_U) $display("FAIL rst_pmp_priv: got %0d want %0d", pmp_priv_lvl_o, PRIV_LVL_U); else n_pass++;
    @(negedge clk); #1;
    n_total++; if (if_rsp_valid_o !== 1'b0 || lsu_rsp_valid_o !== 1'b0)
      $display("FAIL rst_rsp_valid: got if=%0b lsu=%0b want 0 0", if_rsp_valid_o, lsu_rsp_valid_o); else n_pass++;
`ifdef CV32E40S_PMP_SCHED_ERR_CAPTURE_EN
    n_total++; if (err_valid_o !== 1'b0 || err_addr_o !== 34'h0)
      $display("FAIL rst_err_capture: got valid=%0b addr=%0h want 0 0", err_valid_o, err_addr_o); else n_pass++;
`endif
    idle_inputs();
    rst = 1'b0;
    priv_lvl_i = PRIV_LVL_M;
  endtask

  task automatic test_aligned_read();
    fault_en = 1'b1; fault_a = 34'h1003; fault_b = 34'h2_DEAD_BEE0;
    @(negedge clk);
    drive_lsu(34'h1000, 2'd2, 1'b0); lsu_req_dbg_i = 1'b1;
    #1;
    n_total++; if (lsu_req_ready_o !== 1'b1 || if_req_ready_o !== 1'b0)
      $display("FAIL aligned_ready: got lsu=%0b if=%0b want 1 0", lsu_req_ready_o, if_req_ready_o); else n_pass++;
    n_total++; if (pmp_req_addr_o !== 34'h1000 || pmp_req_type_o !== PMP_ACC_READ || pmp_req_dbg_o !== 1'b1)
      $display("FAIL aligned_pmp: got addr=%0h type=%0d dbg=%0b want 1000 %0d 1", pmp_req_addr_o, pmp_req_type_o, pmp_req_dbg_o, PMP_ACC_READ); else n_pass++;
    lsu_q.push_back('{faulty(34'h1000), cyc + 1});
    @(negedge clk);
    drive_lsu(34'h1003, 2'd0, 1'b0); lsu_req_dbg_i = 1'b0;
    #1;
    n_total++; if (lsu_req_ready_o !== 1'b1) $display("FAIL rsp_cycle_ready: got %0b want 1", lsu_req_ready_o); else n_pass++;
    lsu_q.push_back('{faulty(34'h1003), cyc + 1});
    @(negedge clk);
    idle_inputs();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_round_robin();
    logic exp_lsu;
    fault_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if_req_valid_i = 1'b1; if_req_addr_i = 34'h100 + 34'(4 * i);
      drive_lsu(34'h200 + 34'(4 * i), 2'd2, 1'b0);
      #1;
      exp_lsu = (i % 2 == 0);
      n_total++; if (lsu_req_ready_o !== exp_lsu || if_req_ready_o !== !exp_lsu)
        $display("FAIL rr_grant_%0d: got lsu=%0b if=%0b want lsu=%0b", i, lsu_req_ready_o, if_req_ready_o, exp_lsu); else n_pass++;
      n_total++; if (pmp_req_type_o !== (exp_lsu ? PMP_ACC_READ : PMP_ACC_EXEC))
        $display("FAIL rr_type_%0d: got %0d want %0d", i, pmp_req_type_o, exp_lsu ? PMP_ACC_READ : PMP_ACC_EXEC); else n_pass++;
      if (exp_lsu) lsu_q.push_back('{1'b0, cyc + 1});
      else         if_q.push_back('{1'b0, cyc + 1});
    end
    @(negedge clk);
    lsu_req_valid_i = 1'b0; if_req_addr_i = 34'h180;
    #1;
    n_total++; if (if_req_ready_o !== 1'b1 || pmp_req_addr_o !== 34'h180)
      $display("FAIL rr_sole_if: got ready=%0b addr=%0h want 1 180", if_req_ready_o, pmp_req_addr_o); else n_pass++;
    if_q.push_back('{1'b0, cyc + 1});
    @(negedge clk);
    idle_inputs();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_split_write();
    fault_en = 1'b1; fault_a = 34'h1004; fault_b = 34'h1006;
    @(negedge clk);
    drive_lsu(34'h1002, 2'd2, 1'b1);
    #1;
    n_total++; if (lsu_req_ready_o !== 1'b1 || pmp_req_addr_o !== 34'h1002 || pmp_req_type_o !== PMP_ACC_WRITE)
      $display("FAIL split_first: got ready=%0b addr=%0h type=%0d want 1 1002 %0d", lsu_req_ready_o, pmp_req_addr_o, pmp_req_type_o, PMP_ACC_WRITE); else n_pass++;
    lsu_q.push_back('{faulty(34'h1002) | faulty(next_word(34'h1002)), cyc + 2});
    @(negedge clk);
    lsu_req_valid_i = 1'b0;
    if_req_valid_i = 1'b1; if_req_addr_i = 34'h500;
    priv_lvl_i = PRIV_LVL_U;
    #1;
    n_total++; if (if_req_ready_o !== 1'b0 || lsu_req_ready_o !== 1'b0)
      $display("FAIL split_stall: got if=%0b lsu=%0b want 0 0", if_req_ready_o, lsu_req_ready_o); else n_pass++;
    n_total++; if (pmp_req_addr_o !== 34'h1004 || pmp_req_type_o !== PMP_ACC_WRITE)
      $display("FAIL split_second: got addr=%0h type=%0d want 1004 %0d", pmp_req_addr_o, pmp_req_type_o, PMP_ACC_WRITE); else n_pass++;
    n_total++; if (pmp_priv_lvl_o !== PRIV_LVL_M)
      $display("FAIL split_priv_held: got %0d want %0d", pmp_priv_lvl_o, PRIV_LVL_M); else n_pass++;
    @(negedge clk);
    #1;
    n_total++; if (if_req_ready_o !== 1'b1 || pmp_req_type_o !== PMP_ACC_EXEC)
      $display("FAIL split_if_after: got ready=%0b type=%0d want 1 %0d", if_req_ready_o, pmp_req_type_o, PMP_ACC_EXEC); else n_pass++;
    if_q.push_back('{faulty(34'h500), cyc + 1});
    @(negedge clk);
    idle_inputs();
    priv_lvl_i = PRIV_LVL_M;
    drive_lsu(34'h1006, 2'd2, 1'b0);
    #1;
    lsu_q.push_back('{faulty(34'h1006) | faulty(next_word(34'h1006)), cyc + 2});
    @(negedge clk);
    idle_inputs();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_split_boundary();
    logic [33:0] tab_addr[5] = '{34'h2003, 34'h2003, 34'h2002, 34'h2001, 34'h2000};
    logic [1:0]  tab_size[5] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2};
    logic        prev_split = 1'b0;
    logic        sp;
    fault_en = 1'b1; fault_a = 34'h2004; fault_b = 34'h2_DEAD_BEE0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive_lsu(tab_addr[i], tab_size[i], 1'b0);
      #1;
      if (prev_split) begin
        n_total++; if (lsu_req_ready_o !== 1'b0) $display("FAIL bnd_stall_%0d: got %0b want 0", i, lsu_req_ready_o); else n_pass++;
        @(negedge clk); #1;
      end
      n_total++; if (lsu_req_ready_o !== 1'b1 || pmp_req_addr_o !== tab_addr[i])
        $display("FAIL bnd_accept_%0d: got ready=%0b addr=%0h want 1 %0h", i, lsu_req_ready_o, pmp_req_addr_o, tab_addr[i]); else n_pass++;
      sp = splits(tab_addr[i], tab_size[i]);
      lsu_q.push_back('{faulty(tab_addr[i]) | (sp & faulty(next_word(tab_addr[i]))), cyc + (sp ? 2 : 1)});
      prev_split = sp;
    end
    @(negedge clk);
    idle_inputs();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_split_wrap();
    fault_en = 1'b1; fault_a = 34'h0; fault_b = 34'h2_DEAD_BEE0;
    @(negedge clk);
    drive_lsu(34'h3_FFFF_FFFE, 2'd2, 1'b0);
    #1;
    lsu_q.push_back('{faulty(34'h3_FFFF_FFFE) | faulty(next_word(34'h3_FFFF_FFFE)), cyc + 2});
    @(negedge clk);
    lsu_req_valid_i = 1'b0;
    if_req_valid_i = 1'b1; if_req_addr_i = 34'h600;
    #1;
    n_total++; if (pmp_req_addr_o !== 34'h0 || if_req_ready_o !== 1'b0)
      $display("FAIL wrap_second: got addr=%0h if_ready=%0b want 0 0", pmp_req_addr_o, if_req_ready_o); else n_pass++;
    @(negedge clk);
    #1;
    if_q.push_back('{faulty(34'h600), cyc + 1});
    @(negedge clk);
    if_req_valid_i = 1'b0;
    drive_lsu(34'h3_FFFF_FFFE, 2'd1, 1'b0);
    #1;
    lsu_q.push_back('{faulty(34'h3_FFFF_FFFE), cyc + 1});
    @(negedge clk);
    drive_lsu(34'h3000, 2'd2, 1'b0);
    #1;
    n_total++; if (lsu_req_ready_o !== 1'b1) $display("FAIL wrap_half_unsplit: got ready=%0b want 1", lsu_req_ready_o); else n_pass++;
    lsu_q.push_back('{faulty(34'h3000), cyc + 1});
    @(negedge clk);
    idle_inputs();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_split_reset();
    fault_en = 1'b0;
    @(negedge clk);
    drive_lsu(34'h1002, 2'd2, 1'b0);
    @(negedge clk);
    lsu_req_valid_i = 1'b0;
    rst = 1'b1;
    #1;
    n_total++; if (lsu_req_ready_o !== 1'b0 || if_req_ready_o !== 1'b0)
      $display("FAIL splitrst_ready: got lsu=%0b if=%0b want 0 0", lsu_req_ready_o, if_req_ready_o); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_total++; if (lsu_rsp_valid_o !== 1'b0 || lsu_rsp_err_o !== 1'b0)
      $display("FAIL splitrst_rsp: got valid=%0b err=%0b want 0 0", lsu_rsp_valid_o, lsu_rsp_err_o); else n_pass++;
    n_total++; if (pmp_req_addr_o !== 34'h0 || pmp_req_type_o !== PMP_ACC_READ)
      $display("FAIL splitrst_pmp_idle: got addr=%0h type=%0d want 0 %0d", pmp_req_addr_o, pmp_req_type_o, PMP_ACC_READ); else n_pass++;
    drive_lsu(34'h1010, 2'd2, 1'b0);
    #1;
    n_total++; if (lsu_req_ready_o !== 1'b1 || pmp_req_addr_o !== 34'h1010)
      $display("FAIL splitrst_idle: got ready=%0b addr=%0h want 1 1010", lsu_req_ready_o, pmp_req_addr_o); else n_pass++;
    lsu_q.push_back('{1'b0, cyc + 1});
    @(negedge clk);
    idle_inputs();
    repeat (2) @(negedge clk);
  endtask

`ifdef CV32E40S_PMP_SCHED_ERR_CAPTURE_EN
  task automatic test_err_capture();
    fault_en = 1'b1; fault_a = 34'h2000; fault_b = 34'h3000;
    @(negedge clk);
    drive_lsu(34'h2000, 2'd2, 1'b0);
    #1;
    lsu_q.push_back('{1'b1, cyc + 1});
    @(negedge clk);
    drive_lsu(34'h3000, 2'd2, 1'b1);
    #1;
    lsu_q.push_back('{1'b1, cyc + 1});
    @(negedge clk);
    idle_inputs();
    #1;
    n_total++; if (err_valid_o !== 1'b1 || err_addr_o !== 34'h2000 || err_type_o !== PMP_ACC_READ)
      $display("FAIL cap_first: got valid=%0b addr=%0h type=%0d want 1 2000 %0d", err_valid_o, err_addr_o, err_type_o, PMP_ACC_READ); else n_pass++;
    @(negedge clk);
    err_clear_i = 1'b1;
    drive_lsu(34'h3000, 2'd2, 1'b0);
    #1;
    lsu_q.push_back('{1'b1, cyc + 1});
    @(negedge clk);
    err_clear_i = 1'b0;
    idle_inputs();
    #1;
    n_total++; if (err_valid_o !== 1'b0) $display("FAIL cap_clear: got %0b want 0", err_valid_o); else n_pass++;
    repeat (2) @(negedge clk);
  endtask
`endif

  initial begin
    rst = 1'b1;
    priv_lvl_i = PRIV_LVL_M;
    if_req_addr_i = '0; lsu_req_addr_i = '0; lsu_req_size_i = 2'd0;
    idle_inputs();
    fault_en = 1'b0; fault_a = '0; fault_b = '0;
`ifdef CV32E40S_PMP_SCHED_ERR_CAPTURE_EN
    err_clear_i = 1'b0;
`endif
    repeat (2) @(negedge clk);
    test_reset();
    test_aligned_read();
    test_reset();
    test_round_robin();
    test_split_write();
    test_split_boundary();
    test_split_wrap();
    test_split_reset();
`ifdef CV32E40S_PMP_SCHED_ERR_CAPTURE_EN
    test_reset();
    test_err_capture();
`endif
    repeat (3) @(negedge clk);
    #1;
    n_total++; if (if_q.size() != 0) $display("FAIL if_q_drain: got %0d pending want 0", if_q.size()); else n_pass++;
    n_total++; if (lsu_q.size() != 0) $display("FAIL lsu_q_drain: got %0d pending want 0", lsu_q.size()); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
